// File: rtl/multdiv_iter.sv
// Iterative signed multiplier (shift/add) and non-restoring divider over WIDTH bits.
// Define MULTDIV_ITER_BOOTH4_EN for a radix-4 modified Booth multiply (WIDTH/2 steps).
module multdiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_ITER_BOOTH4_EN
    localparam logic [CW-1:0] MulLast = CW'(WIDTH / 2);
`else
    localparam logic [CW-1:0] MulLast  = CW'(WIDTH);
    localparam logic [CW-1:0] MulFinal = CW'(WIDTH - 1);
`endif
    localparam logic [CW-1:0]    DivLast = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;     // multiplicand, or divisor magnitude
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier/dividend bits out, product/quotient bits in
    logic [WIDTH+1:0] acc_q, acc_d;     // product high half, or signed partial remainder
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d, rem_q, rem_d;
    logic             exc_q, exc_d;

    logic start_one, start_both;
    assign start_one  = ctrl_MULT ^ ctrl_DIV;
    assign start_both = ctrl_MULT & ctrl_DIV;

    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;

    // One multiply step: next high half and next low half.
    logic [WIDTH+1:0] mul_acc;
    logic [WIDTH-1:0] mul_lo;
`ifdef MULTDIV_ITER_BOOTH4_EN
    logic             booth_q, booth_d;
    logic [WIDTH+1:0] b4_hi, b4_a, b4_pp, b4_sum;
    assign b4_hi = {{2{acc_q[WIDTH-1]}}, acc_q[WIDTH-1:0]};
    assign b4_a  = {{2{opa_q[WIDTH-1]}}, opa_q};
    always_comb begin
        b4_pp = '0;
        case ({lo_q[1:0], booth_q})
            3'b001, 3'b010: b4_pp = b4_a;
            3'b011:         b4_pp = b4_a << 1;
            3'b100:         b4_pp = '0 - (b4_a << 1);
            3'b101, 3'b110: b4_pp = '0 - b4_a;
            default:        b4_pp = '0;
        endcase
    end
    assign b4_sum  = b4_hi + b4_pp;
    assign mul_acc = {{2{b4_sum[WIDTH+1]}}, b4_sum[WIDTH+1:2]};
    assign mul_lo  = {b4_sum[1:0], lo_q[WIDTH-1:2]};
`else
    logic [WIDTH:0] m2_hi, m2_a, m2_pp, m2_sum;
    assign m2_hi = {acc_q[WIDTH-1], acc_q[WIDTH-1:0]};
    assign m2_a  = {opa_q[WIDTH-1], opa_q};
    // The multiplier sign bit carries weight -2^(WIDTH-1), so the last step subtracts.
    assign m2_pp   = !lo_q[0] ? '0 : ((cnt_q == MulFinal) ? ('0 - m2_a) : m2_a);
    assign m2_sum  = m2_hi + m2_pp;
    assign mul_acc = {{2{m2_sum[WIDTH]}}, m2_sum[WIDTH:1]};
    assign mul_lo  = {m2_sum[0], lo_q[WIDTH-1:1]};
`endif

    logic [WIDTH+1:0] dv_sh, dv_d, dv_new;
    logic [WIDTH-1:0] dv_rem;
    assign dv_sh  = {acc_q[WIDTH:0], lo_q[WIDTH-1]};
    assign dv_d   = {2'b00, opa_q};
    assign dv_new = acc_q[WIDTH+1] ? (dv_sh + dv_d) : (dv_sh - dv_d);
    // A negative final partial remainder needs one restoring add.
    assign dv_rem = acc_q[WIDTH+1] ? (acc_q[WIDTH-1:0] + opa_q) : acc_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        rem_d     = rem_q;
        exc_d     = exc_q;
`ifdef MULTDIV_ITER_BOOTH4_EN
        booth_d   = booth_q;
`endif
        if (start_one) begin
            cnt_d = '0;
            acc_d = '0;
            if (ctrl_MULT) begin
                state_d = StMult;
                opa_d   = data_operandA;
                lo_d    = data_operandB;
`ifdef MULTDIV_ITER_BOOTH4_EN
                booth_d = 1'b0;
`endif
            end else begin
                state_d   = StDiv;
                opa_d     = abs_b;
                lo_d      = abs_a;
                neg_quo_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                neg_rem_d = data_operandA[WIDTH-1];
                dz_d      = (data_operandB == '0);
                ovf_d     = (data_operandA == MinVal) && (data_operandB == '1);
            end
        end else if (start_both) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: ;
                StDone: state_d = StIdle;
                StMult: begin
                    if (cnt_q == MulLast) begin
                        state_d  = StDone;
                        result_d = lo_q;
                        rem_d    = '0;
                        exc_d    = (acc_q[WIDTH-1:0] != {WIDTH{lo_q[WIDTH-1]}});
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        acc_d = mul_acc;
                        lo_d  = mul_lo;
`ifdef MULTDIV_ITER_BOOTH4_EN
                        booth_d = lo_q[1];
`endif
                    end
                end
                StDiv: begin
                    if (cnt_q == DivLast) begin
                        state_d  = StDone;
                        result_d = dz_q ? '0 : (neg_quo_q ? ('0 - lo_q) : lo_q);
                        rem_d    = dz_q ? '0 : (neg_rem_q ? ('0 - dv_rem) : dv_rem);
                        exc_d    = dz_q | ovf_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        acc_d = dv_new;
                        lo_d  = {lo_q[WIDTH-2:0], ~dv_new[WIDTH+1]};
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opa_q     <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            rem_q     <= '0;
            exc_q     <= 1'b0;
`ifdef MULTDIV_ITER_BOOTH4_EN
            booth_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            exc_q     <= exc_d;
`ifdef MULTDIV_ITER_BOOTH4_EN
            booth_q   <= booth_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_remainder = rem_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q == StMult) || (state_q == StDiv);
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: vector table at WIDTH=32 plus restart, abort,
// reset and WIDTH=16 sequences.
module tb_multdiv_iter;
`ifdef MULTDIV_ITER_BOOTH4_EN
    localparam int MulLat = 17;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    logic        clock, reset_n;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] opa, opb, res32, rem32;
    logic        exc32, rdy32, busy32;
    logic        m16, d16;
    logic [15:0] a16, b16, res16, rem16;
    logic        exc16, rdy16, busy16;

    multdiv_iter #(.WIDTH(32)) u32 (
        .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_mult), .ctrl_DIV(ctrl_div),
        .data_operandA(opa), .data_operandB(opb), .data_result(res32),
        .data_remainder(rem32), .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32)
    );

    multdiv_iter #(.WIDTH(16)) u16 (
        .clock(clock), .reset_n(reset_n), .ctrl_MULT(m16), .ctrl_DIV(d16),
        .data_operandA(a16), .data_operandB(b16), .data_result(res16),
        .data_remainder(rem16), .data_exception(exc16), .data_resultRDY(rdy16), .busy(busy16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Issue one start (now, or on the next cycle) and wait for RDY; lat counts edges after E0.
    task automatic op32(input bit b2b, input logic div, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
        if (!b2b) begin
            @(posedge clock); #1;
        end
        ctrl_mult = !div; ctrl_div = div; opa = a; opb = b;
        @(posedge clock); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        lat = 0;
        while (!rdy32 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] rem;
        logic        exc;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    initial begin
        int lat;
        int nrdy;
        vec[0]  = '{1'b0, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 32'd0,        1'b0};
        vec[1]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'd0,        1'b1};
        vec[2]  = '{1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd0,        1'b1};
        vec[3]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1};
        vec[4]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'd0,        1'b0};
        vec[5]  = '{1'b0, 32'h00003039, 32'hFFFFFC18, 32'hFF43A158, 32'd0,        1'b0};
        vec[6]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 32'd0,        1'b1};
        vec[7]  = '{1'b1, 32'd5,        32'd0,        32'h00000000, 32'd0,        1'b1};
        vec[8]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1};
        vec[9]  = '{1'b1, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
        vec[10] = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vec[11] = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
        vec[12] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
        vec[13] = '{1'b1, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0};
        vec[14] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};
        vec[15] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0};
        vec[16] = '{1'b1, 32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0};
        vec[17] = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'd0,        32'd0,        1'b1};

        reset_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0; opa = '0; opb = '0;
        m16 = 1'b0; d16 = 1'b0; a16 = '0; b16 = '0;
        #2;
        chk("reset_result", res32, 32'd0);
        chk("reset_rem", rem32, 32'd0);
        chk("reset_exc", exc32, 1'b0);
        chk("reset_rdy", rdy32, 1'b0);
        chk("reset_busy", busy32, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            op32(1'b0, vec[i].div, vec[i].a, vec[i].b, lat);
            chk($sformatf("v%0d_lat", i), lat, vec[i].div ? DivLat : MulLat);
            chk($sformatf("v%0d_result", i), res32, vec[i].res);
            chk($sformatf("v%0d_rem", i), rem32, vec[i].rem);
            chk($sformatf("v%0d_exc", i), exc32, vec[i].exc);
            @(posedge clock); #1;
            chk($sformatf("v%0d_rdy_once", i), rdy32, 1'b0);
        end

        // Back-to-back: second start issued in the RDY cycle of the first.
        op32(1'b0, 1'b1, 32'd100, 32'd7, lat);
        chk("b2b_first_result", res32, 32'd14);
        op32(1'b1, 1'b0, 32'hFFFFFFF9, 32'd6, lat);
        chk("b2b_lat", lat, MulLat);
        chk("b2b_result", res32, 32'hFFFFFFD6);
        repeat (5) @(posedge clock);
        #1;
        chk("hold_result", res32, 32'hFFFFFFD6);
        chk("hold_busy", busy32, 1'b0);

        // Restart a MULT at E10 with a DIV.
        @(posedge clock); #1;
        ctrl_mult = 1'b1; opa = 32'd3; opb = 32'd5;
        @(posedge clock); #1;
        ctrl_mult = 1'b0;
        nrdy = 0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock); #1;
            if (rdy32) nrdy++;
        end
        ctrl_div = 1'b1; opa = 32'd100; opb = 32'd7;
        @(posedge clock); #1;
        ctrl_div = 1'b0;
        lat = 0;
        while (!rdy32 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("restart_no_early_rdy", nrdy, 0);
        chk("restart_lat", lat, DivLat);
        chk("restart_result", res32, 32'd14);
        chk("restart_rem", rem32, 32'd2);

        // Both ctrls mid-operation abort to IDLE with no RDY.
        @(posedge clock); #1;
        ctrl_div = 1'b1; opa = 32'd9; opb = 32'd2;
        @(posedge clock); #1;
        ctrl_div = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        ctrl_mult = 1'b1; ctrl_div = 1'b1;
        @(posedge clock); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        chk("abort_busy", busy32, 1'b0);
        nrdy = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clock); #1;
            if (rdy32) nrdy++;
        end
        chk("abort_no_rdy", nrdy, 0);
        chk("abort_hold_result", res32, 32'd14);

        // Asynchronous reset mid-DIV.
        @(posedge clock); #1;
        ctrl_div = 1'b1; opa = 32'hFFFFFF9C; opb = 32'd7;
        @(posedge clock); #1;
        ctrl_div = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset_result", res32, 32'd0);
        chk("areset_rem", rem32, 32'd0);
        chk("areset_exc", exc32, 1'b0);
        chk("areset_rdy", rdy32, 1'b0);
        chk("areset_busy", busy32, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        ctrl_mult = 1'b1; ctrl_div = 1'b1; opa = 32'd4; opb = 32'd4;
        @(posedge clock); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        nrdy = 0;
        for (int e = 0; e < 3; e++) begin
            if (busy32) nrdy++;
            @(posedge clock); #1;
        end
        chk("both_start_ignored", nrdy, 0);
        chk("both_start_rdy", rdy32, 1'b0);

        // WIDTH=16 divide: -17 / 5.
        @(posedge clock); #1;
        d16 = 1'b1; a16 = 16'hFFEF; b16 = 16'd5;
        @(posedge clock); #1;
        d16 = 1'b0;
        lat = 0;
        while (!rdy16 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("w16_lat", lat, 17);
        chk("w16_result", res16, 16'hFFFD);
        chk("w16_rem", rem16, 16'hFFFE);
        chk("w16_exc", exc16, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multdiv_iter.md
# multdiv_iter

Parametrised iterative signed multiplier/divider; next generation of the core's fixed 32-bit MULT/DIV unit. Accepts a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse and latches both operands on that edge. It then runs a counter-sequenced shift/add (multiply) or non-restoring (divide) datapath over WIDTH bits and returns quotient and remainder. It pulses `data_resultRDY` when done. Sits beside the ALU in the execute stage; the pipeline stalls on `busy`.

## Interface
- WIDTH, 32, operand/result width; even, ≥ 4.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_operandA  in  WIDTH  multiplicand / dividend (two's complement), sampled on the start edge.
- data_operandB  in  WIDTH  multiplier / divisor (two's complement), sampled on the start edge.
- data_result  out  WIDTH  low WIDTH bits of product, or quotient.
- data_remainder  out  WIDTH  divide remainder; 0 after a multiply.
- data_exception  out  1  overflow / divide-by-zero flag for the current result.
- data_resultRDY  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after the start edge through the cycle before RDY.

## Operation
- FSM states: IDLE, MULT, DIV, DONE.
- IDLE: exactly one of ctrl_MULT/ctrl_DIV high → latch operands, clear counter, go MULT/DIV. Both high → ignored.
- MULT:
  - Radix-2: one partial-product step per cycle; the product register is 2·WIDTH bits.
  - Sign handling: subtract the multiplicand on the final (sign-bit) step.
  - After the last step → DONE.
- DIV:
  - Works on magnitudes with a non-restoring algorithm, one quotient bit per cycle.
  - After WIDTH steps → DONE.
  - The DONE entry cycle applies remainder correction and sign fix-up.
- Division rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- DONE: data_resultRDY=1 for exactly one cycle, then → IDLE.
- Result hold: data_result, data_remainder and data_exception stay stable until the next accepted start or reset.
- Exceptions:
  - MULT: data_exception=1 iff the full 2·WIDTH product is not the sign extension of its low WIDTH bits.
  - DIV with B=0: result=0, remainder=0, exception=1; full latency still applies.
  - DIV of MIN/−1: result=MIN, remainder=0, exception=1.
- Start while in MULT/DIV (abort/restart):
  - Exactly one ctrl high → abort the current operation, relatch operands, restart in the new mode. No RDY is issued for the aborted operation.
  - Both high → abort to IDLE.
- Start in DONE: accepted as in IDLE. RDY still pulses that cycle, for the old result.
- Reset (any state, asynchronous): → IDLE. Reset values: data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0, counter=0.

## Timing
- Start sampled on rising edge E0.
- Latency:
  - MULT: data_resultRDY high in the cycle after edge E(WIDTH+1).
  - DIV: same, cycle after E(WIDTH+1).
  - With Booth enabled, MULT completes after E(WIDTH/2+1).
- Outputs change only at rising edges, except on reset.
- Results are valid in the same cycle as RDY.
- Throughput: next start is accepted in the RDY cycle, so back-to-back operations are spaced LAT+1 cycles apart.
- Counter width: $clog2(WIDTH)+1 bits. It wraps only through a restart, never free-runs.

## Configuration
- MULTDIV_ITER_BOOTH4_EN defined:
  - MULT uses radix-4 modified Booth, recoding 3 multiplier bits into {0,±1,±2}×A.
  - Two bits retire per cycle, so MULT takes WIDTH/2 steps.
  - Product and exception are identical to radix-2.
- Undefined: radix-2 MULT as above.
- DIV is unaffected either way.

## Test plan
- WIDTH=32, MULT A=−7, B=6 → RDY once at E33 (E17 with Booth), result=0xFFFFFFD6, exception=0, remainder=0.
- WIDTH=32, MULT A=0x00010000, B=0x00010000 → result=0x00000000, exception=1.
- WIDTH=16, DIV A=−17, B=5 → RDY at E17, result=0xFFFD (−3), remainder=0xFFFE (−2), exception=0.
- WIDTH=32:
  - DIV A=5, B=0 → result=0, remainder=0, exception=1.
  - DIV A=0x80000000, B=−1 → result=0x80000000, exception=1.
- Restart at E10 of a MULT with ctrl_DIV, A=100, B=7 → no RDY for the MULT; RDY at E10+33 with result=14, remainder=2.
- reset_n low mid-DIV, asynchronous to clock:
  - Immediately: all outputs 0, busy=0.
  - After release, a start with both ctrls high → no operation, busy stays 0.
